// File: rtl/tdes_pkg.sv
// Shared DES tables, state encoding and permutation/key-schedule helpers for the TDES engine.
// Pure constants and combinational functions only: no latency, no flow control.
package tdes_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam int KM_THREE  = 0;
    localparam int KM_TWO    = 1;
    localparam int KM_SINGLE = 2;

    // Tables use the DES convention: position 1 is the MSB.
    localparam int IP_T [0:63] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [0:63] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [0:47] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each box is stored row-major: index = row*16 + col.
    localparam int SBOX [0:7][0:63] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [63:0] ip_perm(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - IP_T[i])];
        return o;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - FP_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] d);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = d[5'(32 - E_T[i])];
        return o;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] d);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = d[5'(32 - P_T[i])];
        return o;
    endfunction

    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] o;
        logic [5:0]  c;
        o = '0;
        for (int b = 0; b < 8; b++) begin
            c = x[6'(47 - 6 * b) -: 6];
            o[5'(31 - 4 * b) -: 4] = 4'(SBOX[3'(b)][{c[5], c[0], c[4:1]}]);
        end
        return o;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
        logic [55:0] d;
        d = {v, v};
        return d[6'(55 - n) -: 28];
    endfunction

    // Subkey K(k+1) derived directly from the key: total rotation is the running sum of the schedule.
    function automatic logic [47:0] subkey(input logic [63:0] key, input logic [3:0] k);
        logic [55:0] cd;
        int          n;
        cd = '0;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_T[i])];
        n = 0;
        for (int j = 0; j < 16; j++) if (j <= int'(k)) n += SHIFTS[j];
        cd = {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
        subkey = '0;
        for (int i = 0; i < 48; i++) subkey[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: (L, R, K) -> (R, L ^ f(R, K)).
// Zero latency, no flow control.
module des_round import tdes_pkg::*; (
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [47:0] subkey,
    output logic [31:0] l_next,
    output logic [31:0] r_next
);

    logic [47:0] mixed;
    logic [31:0] subst;

    assign mixed  = e_expand(r) ^ subkey;
    assign subst  = sbox_sub(mixed);
    assign l_next = r;
    assign r_next = l ^ p_perm(subst);

endmodule

// File: rtl/tdes_engine.sv
// Iterative triple-DES engine, ROUNDS_PER_CYCLE rounds per clock; result 48/RPC+1 cycles after ready.
// Requests arriving while busy are dropped; one block in flight at a time.
module tdes_engine import tdes_pkg::*; #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int KEY_MODE         = KM_THREE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    input  logic        ed_sel,
    input  logic        ready,
    output logic [63:0] data_out,
    output logic        next_data,
    output logic        busy
);

    localparam logic [3:0] RND_LAST = 4'(16 / ROUNDS_PER_CYCLE - 1);

    state_t      state;
    logic [63:0] lr;
    logic [63:0] k1, k2, k3;
    logic        ed;
    logic [1:0]  stage;
    logic [3:0]  rnd;

    logic [63:0] key2_eff, key3_eff, key_sel;
    logic        stage_dec;
    logic [31:0] l_end, r_end;

    assign key2_eff = (KEY_MODE == KM_SINGLE) ? key1 : key2;
    assign key3_eff = (KEY_MODE == KM_THREE)  ? key3 : key1;

    // Encrypt runs E/D/E with k1,k2,k3; decrypt runs D/E/D with k3,k2,k1.
    assign stage_dec = (stage == 2'd1) ? ed : !ed;
    assign key_sel   = (stage == 2'd1) ? k2 : (((stage == 2'd0) == ed) ? k1 : k3);

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        logic [31:0] l_cur, r_cur, l_nxt, r_nxt;
        logic [3:0]  ridx, kidx;
        logic [47:0] sk;

        if (g == 0) begin : g_head
            assign l_cur = lr[63:32];
            assign r_cur = lr[31:0];
        end else begin : g_link
            assign l_cur = g_rnd[g-1].l_nxt;
            assign r_cur = g_rnd[g-1].r_nxt;
        end

        assign ridx = 4'(int'(rnd) * ROUNDS_PER_CYCLE + g);
        assign kidx = stage_dec ? (4'd15 - ridx) : ridx;
        assign sk   = subkey(key_sel, kidx);

        des_round u_round (
            .l      (l_cur),
            .r      (r_cur),
            .subkey (sk),
            .l_next (l_nxt),
            .r_next (r_nxt)
        );
    end

    assign l_end = g_rnd[ROUNDS_PER_CYCLE-1].l_nxt;
    assign r_end = g_rnd[ROUNDS_PER_CYCLE-1].r_nxt;

    assign busy      = (state != ST_IDLE);
    assign next_data = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            lr       <= '0;
            k1       <= '0;
            k2       <= '0;
            k3       <= '0;
            ed       <= 1'b0;
            stage    <= 2'd0;
            rnd      <= 4'd0;
            data_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready) begin
                        state <= ST_LOAD;
                        lr    <= ip_perm(data_in);
                        k1    <= key1;
                        k2    <= key2_eff;
                        k3    <= key3_eff;
                        ed    <= ed_sel;
                        stage <= 2'd0;
                        rnd   <= 4'd0;
                    end
                end
                ST_LOAD: begin
                    state <= ST_RUN;
                    stage <= 2'd0;
                    rnd   <= 4'd0;
                end
                ST_RUN: begin
                    // Stage boundary: apply the DES final swap; the FP/IP pair in between cancels.
                    if (rnd == RND_LAST) begin
                        lr  <= {r_end, l_end};
                        rnd <= 4'd0;
                        if (stage == 2'd2) begin
                            state    <= ST_DONE;
                            stage    <= 2'd0;
                            data_out <= fp_perm({r_end, l_end});
                        end else begin
                            stage <= stage + 2'd1;
                        end
                    end else begin
                        lr  <= {l_end, r_end};
                        rnd <= rnd + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdes_engine.sv
// Directed-vector bench for tdes_engine across round widths and key modes.
module tb_tdes_engine;

    localparam logic [63:0] K0  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT0 = 64'h85E813540F0AB405;
    localparam logic [63:0] KA  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KB  = 64'h23456789ABCDEF01;
    localparam logic [63:0] KC  = 64'h456789ABCDEF0123;
    localparam logic [63:0] PT1 = 64'h5468652071756663;
    localparam logic [63:0] CT1 = 64'hA826FD8CE53B855F;
    localparam logic [63:0] PT2 = 64'h2E0618E5790A7B59;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        ed_sel;
    logic [63:0] data_in, key1, key2, key3;
    logic [63:0] dout [4];
    logic        nd   [4];
    logic        bsy  [4];

    int          total = 0;
    int          bad   = 0;
    int          lat    [4];
    int          npulse [4];
    int          exp_lat[4];
    logic [63:0] res    [4];

    always #5 clk = ~clk;

    // 0: 1 round/cycle single-key, 1: 1 round/cycle three-key, 2: 2 rounds, 3: 4 rounds
    tdes_engine #(.ROUNDS_PER_CYCLE(1), .KEY_MODE(2)) u_s1 (
        .clk(clk), .rst(rst), .data_in(data_in), .key1(key1), .key2(key2), .key3(key3),
        .ed_sel(ed_sel), .ready(ready), .data_out(dout[0]), .next_data(nd[0]), .busy(bsy[0]));
    tdes_engine #(.ROUNDS_PER_CYCLE(1), .KEY_MODE(0)) u_t1 (
        .clk(clk), .rst(rst), .data_in(data_in), .key1(key1), .key2(key2), .key3(key3),
        .ed_sel(ed_sel), .ready(ready), .data_out(dout[1]), .next_data(nd[1]), .busy(bsy[1]));
    tdes_engine #(.ROUNDS_PER_CYCLE(2), .KEY_MODE(2)) u_s2 (
        .clk(clk), .rst(rst), .data_in(data_in), .key1(key1), .key2(key2), .key3(key3),
        .ed_sel(ed_sel), .ready(ready), .data_out(dout[2]), .next_data(nd[2]), .busy(bsy[2]));
    tdes_engine #(.ROUNDS_PER_CYCLE(4), .KEY_MODE(2)) u_s4 (
        .clk(clk), .rst(rst), .data_in(data_in), .key1(key1), .key2(key2), .key3(key3),
        .ed_sel(ed_sel), .ready(ready), .data_out(dout[3]), .next_data(nd[3]), .busy(bsy[3]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts one block on all instances and watches 60 cycles; poke_at re-asserts ready
    // with scrambled inputs on that cycle while the block is in flight.
    task automatic run_block(input logic [63:0] din, input logic ed, input logic [63:0] ka,
                             input logic [63:0] kb, input logic [63:0] kc, input int poke_at);
        data_in = din; ed_sel = ed; key1 = ka; key2 = kb; key3 = kc; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            npulse[i] = 0; lat[i] = 0; res[i] = '0;
        end
        @(posedge clk); #1;
        ready = 1'b0;
        chk("busy_in_load", 64'(bsy[0]), 64'd1);
        for (int c = 1; c <= 60; c++) begin
            if (c == poke_at) begin
                ready = 1'b1; data_in = ~din; ed_sel = ~ed; key1 = ~ka; key2 = ~kb; key3 = ~kc;
            end else begin
                ready = 1'b0;
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (nd[i]) begin
                    npulse[i]++;
                    if (npulse[i] == 1) begin
                        lat[i] = c;
                        res[i] = dout[i];
                    end
                end
            end
        end
    endtask

    initial begin
        logic [63:0] ct;
        int          cnt;
        int          ta [2];
        int          tb [2];
        int          na, nb;

        exp_lat[0] = 49; exp_lat[1] = 49; exp_lat[2] = 25; exp_lat[3] = 13;
        rst = 1'b1; ready = 1'b0; ed_sel = 1'b0;
        data_in = '0; key1 = '0; key2 = '0; key3 = '0;
        #2;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_dout%0d", i), dout[i], 64'd0);
            chk($sformatf("rst_busy%0d", i), 64'(bsy[i]), 64'd0);
            chk($sformatf("rst_nd%0d", i), 64'(nd[i]), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Classic single-DES vector on every instance (three equal keys for the 3-key one).
        run_block(PT0, 1'b1, K0, K0, K0, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("enc_res%0d", i), res[i], CT0);
            chk($sformatf("enc_lat%0d", i), 64'(lat[i]), 64'(exp_lat[i]));
            chk($sformatf("enc_pulses%0d", i), 64'(npulse[i]), 64'd1);
        end
        chk("idle_busy", 64'(bsy[0]), 64'd0);
        chk("dout_hold", dout[0], CT0);

        // Decrypt; key2/key3 garbage must be ignored in single-key mode.
        run_block(CT0, 1'b0, K0, '1, '0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i != 1) chk($sformatf("dec_res%0d", i), res[i], PT0);
        end

        run_block(PT1, 1'b1, KA, KB, KC, 0);
        chk("tdes_known", res[1], CT1);

        run_block(PT2, 1'b1, KA, KB, KC, 0);
        ct = res[1];
        chk("tdes_enc_lat", 64'(lat[1]), 64'd49);
        run_block(ct, 1'b0, KA, KB, KC, 0);
        chk("tdes_roundtrip", res[1], PT2);

        // Ready during RUN with changed inputs must be dropped.
        run_block(PT0, 1'b1, K0, K0, K0, 11);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("poke_res%0d", i), res[i], CT0);
            chk($sformatf("poke_pulses%0d", i), 64'(npulse[i]), 64'd1);
        end

        // Reset 20 cycles into RUN.
        data_in = PT1; ed_sel = 1'b1; key1 = K0; key2 = K0; key3 = K0; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("run_busy", 64'(bsy[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(bsy[0]), 64'd0);
        chk("abort_dout", dout[0], 64'd0);
        chk("abort_nd", 64'(nd[0]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (nd[0]) cnt++;
        end
        chk("abort_no_pulse", 64'(cnt), 64'd0);

        run_block(PT0, 1'b1, K0, K0, K0, 0);
        chk("post_rst_res", res[0], CT0);
        chk("post_rst_lat", 64'(lat[0]), 64'd49);

        // Ready held high: back-to-back blocks every N+3 cycles.
        data_in = PT0; ed_sel = 1'b1; key1 = K0; key2 = K0; key3 = K0; ready = 1'b1;
        na = 0; nb = 0;
        ta[0] = 0; ta[1] = 0; tb[0] = 0; tb[1] = 0;
        for (int c = 0; c <= 110; c++) begin
            @(posedge clk); #1;
            if (nd[0] && na < 2) begin ta[na] = c; na++; end
            if (nd[3] && nb < 2) begin tb[nb] = c; nb++; end
            if (c == 60) begin
                chk("thru_hold", dout[0], CT0);
                chk("thru_busy", 64'(bsy[0]), 64'd1);
            end
        end
        ready = 1'b0;
        chk("thru_first", 64'(ta[0]), 64'd49);
        chk("thru_gap1", 64'(ta[1] - ta[0]), 64'd51);
        chk("thru_gap4", 64'(tb[1] - tb[0]), 64'd15);
        repeat (60) @(posedge clk);
        #1;
        chk("thru_res", dout[0], CT0);
        chk("thru_idle", 64'(bsy[0]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
